dmux_sched: RTL and testbench
=============================

Name: dmux_sched

Overview:
- Sequencing controller for the 1-to-N demultiplexer datapath.
- Takes a valid/ready input stream and steers each word to one of N_OUT destinations through a single-entry output register.
- Destination order is either strict round-robin with a configurable burst length, or a fixed destination.
- Sits between an upstream producer and N_OUT sink blocks. Replaces free-running select counters in front of demux outputs.

Parameters:
- N_OUT, 8, number of destinations (power of two, 2..16).
- SEL_W, 3, select width, equal to log2(N_OUT).
- DW, 8, data word width.
- BL_W, 4, burst-length config width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  controller accepts in_data this cycle.
- out_data  out  DW  held word, broadcast to all sinks.
- out_valid  out  N_OUT  one-hot; bit k high means the word is for sink k.
- out_ready  in  N_OUT  per-sink ready.
- mode  in  1  0 = round-robin, 1 = fixed destination.
- fix_sel  in  SEL_W  destination used when mode=1.
- burst_len  in  BL_W  words per destination before rotating; 0 is treated as 1.
- cur_sel  out  SEL_W  destination the next accepted word will take.
- busy  out  1  output register loaded.

Behaviour:
- Reset (async assert, sync release):
  - FSM=EMPTY; out_valid=0, out_data=0, cur_sel=0, busy=0.
  - Burst counter cnt=0; config registers cfg_mode=0, cfg_fix=0, cfg_bl=1.
- FSM has two states, EMPTY and LOADED:
  - EMPTY: in_ready=1. If in_valid, capture in_data and dest=next_sel, then go to LOADED.
  - LOADED: out_valid = onehot(dest). Delivery occurs when out_ready[dest]=1.
  - Delivery with in_valid=1: capture the new word in the same cycle, stay LOADED. Zero-bubble throughput of 1 word/cycle.
  - Delivery with in_valid=0: go to EMPTY.
  - No delivery: hold data and dest; in_ready=0.
  - in_ready = (state==EMPTY) | (out_ready[dest] in LOADED). Combinational from out_ready only; never from in_valid.
- Config sampling:
  - mode, fix_sel and burst_len are copied into cfg_* only on cycles where state==EMPTY and in_valid=0.
  - Config changes while words are flowing take effect at the next idle cycle.
  - When the sampled config differs from cfg_*, reset cnt=0. cur_sel is unchanged in round-robin mode.
- Round-robin (cfg_mode=0):
  - On each delivery, cnt++. When cnt+1 == max(cfg_bl,1): cnt=0 and cur_sel = (cur_sel+1) mod N_OUT.
  - Wrap from N_OUT-1 to 0.
  - next_sel is cur_sel after this cycle's update. A word captured in the same cycle as a rotating delivery goes to the new destination.
- Fixed (cfg_mode=1): next_sel=cfg_fix. cnt and cur_sel are frozen. The cur_sel output shows cfg_fix.
- Rotation is strict: a non-ready sink stalls the stream. There is no skipping.
- out_ready bits other than dest are ignored.
- out_data is updated only on capture, and holds its value in EMPTY.
- busy = (state==LOADED).
- Reset asserted mid-transfer: the held word is discarded, and all outputs return to reset values immediately (asynchronously).

Decomposition:
- Shared package dmux_pkg:
  - state encoding ST_EMPTY=1'b0, ST_LOADED=1'b1.
  - mode constants MODE_RR=1'b0, MODE_FIX=1'b1.
  - a onehot function (SEL_W to N_OUT).
- One sub-module, dmux_rr_ptr: holds cur_sel and cnt, takes advance/cfg inputs, and produces next_sel.
- The top level holds the FSM, data register and config registers.

Test Plan:
- Reset then idle: rst_n low for 2 cycles → out_valid=8'h00, cur_sel=0, in_ready=1, busy=0.
- Round-robin, burst_len=1, all out_ready=1, streaming 8'hA0..8'hA8 back-to-back → one word per cycle delivered to sinks 0,1,…,7 then 0. The 9th word (A8) goes to sink 0 (wrap), with no bubble.
- Burst: burst_len=3, 7 words, all ready → sinks 0,0,0,1,1,1,2; cur_sel=2 and cnt=1 at the end.
- Backpressure: word 8'h55 with dest=2 and out_ready[2]=0 for 4 cycles, other ready bits=1 → out_valid=8'h04 held with out_data=8'h55, in_ready=0. It delivers on the cycle out_ready[2]=1.
- Fixed mode: mode=1 and fix_sel=5 while idle, then 3 words → all go with out_valid=8'h20. A mode change while LOADED is ignored until the next EMPTY-idle cycle.
- Async reset mid-transfer: assert rst_n while LOADED and stalled → out_valid=0 and busy=0 in the same cycle without a clock edge. After release, the first word goes to sink 0.

Source files
------------

// File: rtl/dmux_pkg.sv
// -----------------------------------------------------------------------------
// dmux_pkg
// Shared definitions for the dmux_sched sequencing controller.
//   - datapath / config widths
//   - FSM state encoding (EMPTY / LOADED)
//   - steering mode constants (round-robin / fixed destination)
//   - onehot(): destination index -> one-hot sink valid vector
// -----------------------------------------------------------------------------
package dmux_pkg;

    localparam int N_OUT = 8;   // number of destinations (power of two, 2..16)
    localparam int SEL_W = 3;   // log2(N_OUT)
    localparam int DW    = 8;   // data word width
    localparam int BL_W  = 4;   // burst-length config width

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_e;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

    function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [N_OUT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dmux_sched_if.sv
// -----------------------------------------------------------------------------
// dmux_sched_if
// Stream bundle around the scheduler.
//
// Handshake: a word moves on in_* when in_valid && in_ready at a rising edge;
// a word moves to sink k when out_valid[k] && out_ready[k] at a rising edge.
// A producer holds in_data/in_valid stable until accepted; the scheduler holds
// out_data/out_valid stable until delivered. in_ready never depends on
// in_valid.
//
//   in_data   producer -> scheduler   input word
//   in_valid  producer -> scheduler   input word present
//   in_ready  scheduler -> producer   word accepted this cycle
//   out_data  scheduler -> sinks      held word (broadcast)
//   out_valid scheduler -> sinks      one-hot destination
//   out_ready sinks -> scheduler      per-sink ready
//
// master: environment side (producer + sinks); slave: the scheduler.
// -----------------------------------------------------------------------------
interface dmux_sched_if
    import dmux_pkg::*;
();
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    out_data;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/dmux_rr_ptr.sv
// -----------------------------------------------------------------------------
// dmux_rr_ptr
// Round-robin destination pointer with burst counting.
//   clk, rst_n    clock, async active-low reset
//   advance_i     a word is delivered this cycle
//   cfg_clr_i     sampled config changed: restart the burst count
//   cfg_mode_i    MODE_RR / MODE_FIX
//   cfg_fix_i     fixed destination
//   cfg_bl_i      words per destination (0 behaves as 1)
//   cur_sel_o     destination the next accepted word would take right now
//   next_sel_o    destination for a word captured this cycle (after update)
//   cnt_o         burst counter (observability)
// -----------------------------------------------------------------------------
module dmux_rr_ptr
    import dmux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance_i,
    input  logic             cfg_clr_i,
    input  logic             cfg_mode_i,
    input  logic [SEL_W-1:0] cfg_fix_i,
    input  logic [BL_W-1:0]  cfg_bl_i,
    output logic [SEL_W-1:0] cur_sel_o,
    output logic [SEL_W-1:0] next_sel_o,
    output logic [BL_W-1:0]  cnt_o
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [BL_W-1:0]  cnt_q, cnt_d;
    logic [BL_W-1:0]  bl_eff;

    always_comb begin
        bl_eff = (cfg_bl_i == '0) ? BL_W'(1) : cfg_bl_i;
        sel_d  = sel_q;
        cnt_d  = cnt_q;
        if (cfg_clr_i) begin
            cnt_d = '0;
        end else if (advance_i && (cfg_mode_i == MODE_RR)) begin
            // Extra bit keeps cnt+1 from wrapping before the compare.
            if (({1'b0, cnt_q} + 1'b1) == {1'b0, bl_eff}) begin
                cnt_d = '0;
                sel_d = sel_q + 1'b1;   // natural wrap N_OUT-1 -> 0
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    // A word captured alongside a rotating delivery already sees the new sink.
    assign next_sel_o = (cfg_mode_i == MODE_FIX) ? cfg_fix_i : sel_d;
    assign cur_sel_o  = (cfg_mode_i == MODE_FIX) ? cfg_fix_i : sel_q;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/dmux_sched.sv
// -----------------------------------------------------------------------------
// dmux_sched
// Steers a valid/ready input stream to one of N_OUT sinks through a
// single-entry output register, in strict round-robin (with burst length)
// or to a fixed destination. Sustains one word per cycle when the current
// sink is ready.
//   clk, rst_n   clock, async active-low reset
//   bus          stream bundle (slave side), see dmux_sched_if
//   mode         0 = round-robin, 1 = fixed destination
//   fix_sel      destination used in fixed mode
//   burst_len    words per destination before rotating (0 = 1)
//   cur_sel      destination the next accepted word will take
//   busy         output register loaded
//   dbg_state_o  FSM state
// -----------------------------------------------------------------------------
module dmux_sched
    import dmux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    dmux_sched_if.slave      bus,
    input  logic             mode,
    input  logic [SEL_W-1:0] fix_sel,
    input  logic [BL_W-1:0]  burst_len,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output state_e           dbg_state_o
);

    state_e           state_q;
    logic [DW-1:0]    data_q;
    logic [SEL_W-1:0] dest_q;
    logic [N_OUT-1:0] out_valid_q;

    logic             cfg_mode_q;
    logic [SEL_W-1:0] cfg_fix_q;
    logic [BL_W-1:0]  cfg_bl_q;

    logic             deliver;
    logic             in_ready;
    logic             capture;
    logic             cfg_sample;
    logic             cfg_clr;
    logic [SEL_W-1:0] next_sel;
    logic [BL_W-1:0]  cnt_unused;

    always_comb begin
        deliver    = (state_q == ST_LOADED) && bus.out_ready[dest_q];
        in_ready   = (state_q == ST_EMPTY) || deliver;
        capture    = bus.in_valid && in_ready;
        // Config only moves on truly idle cycles so a stream never sees it change.
        cfg_sample = (state_q == ST_EMPTY) && !bus.in_valid;
        cfg_clr    = cfg_sample && ((mode != cfg_mode_q) ||
                                    (fix_sel != cfg_fix_q) ||
                                    (burst_len != cfg_bl_q));
    end

    dmux_rr_ptr u_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance_i  (deliver),
        .cfg_clr_i  (cfg_clr),
        .cfg_mode_i (cfg_mode_q),
        .cfg_fix_i  (cfg_fix_q),
        .cfg_bl_i   (cfg_bl_q),
        .cur_sel_o  (cur_sel),
        .next_sel_o (next_sel),
        .cnt_o      (cnt_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            data_q      <= '0;
            dest_q      <= '0;
            out_valid_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (capture) begin
                        state_q     <= ST_LOADED;
                        data_q      <= bus.in_data;
                        dest_q      <= next_sel;
                        out_valid_q <= onehot(next_sel);
                    end
                end
                ST_LOADED: begin
                    if (capture) begin
                        // Delivery and refill in the same cycle: no bubble.
                        data_q      <= bus.in_data;
                        dest_q      <= next_sel;
                        out_valid_q <= onehot(next_sel);
                    end else if (deliver) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode_q <= MODE_RR;
            cfg_fix_q  <= '0;
            cfg_bl_q   <= BL_W'(1);
        end else if (cfg_sample) begin
            cfg_mode_q <= mode;
            cfg_fix_q  <= fix_sel;
            cfg_bl_q   <= burst_len;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q == ST_LOADED);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dmux_sched.sv
// -----------------------------------------------------------------------------
// tb_dmux_sched
// Directed bench for dmux_sched. The driver pushes {expected sink, word} into
// exp_q as each word is offered; the monitor pops and compares on every
// delivery (out_valid & out_ready). Point checks cover reset, stalls, config
// timing and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_dmux_sched;
    import dmux_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [SEL_W-1:0] fix_sel;
    logic [BL_W-1:0]  burst_len;
    logic [SEL_W-1:0] cur_sel;
    logic             busy;
    state_e           dbg_state;

    dmux_sched_if bus ();

    dmux_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .mode        (mode),
        .fix_sel     (fix_sel),
        .burst_len   (burst_len),
        .cur_sel     (cur_sel),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;
    int cyc;
    logic [SEL_W+DW-1:0] exp_q[$];
    logic [SEL_W+DW-1:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && ((bus.out_valid & bus.out_ready) != '0)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_delivery: got out_valid 0x%0h data 0x%0h expected no word",
                         bus.out_valid, bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("delivery_sink", 32'(bus.out_valid), 32'd1 << mon_e[SEL_W+DW-1:DW]);
                check("delivery_data", 32'(bus.out_data), 32'(mon_e[DW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one word and return #1 after the edge that accepted it.
    task automatic send_word(input logic [DW-1:0] d, input int sink);
        logic ok;
        exp_q.push_back({SEL_W'(sink), d});
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no in_ready for word 0x%0h expected acceptance", d);
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int t0;

    initial begin
        n_vec         = 0;
        n_err         = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 8'hFF;
        mode          = 1'b0;
        fix_sel       = '0;
        burst_len     = 4'd1;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 'h00);
        check("rst_out_data",  32'(bus.out_data),  'h00);
        check("rst_cur_sel",   32'(cur_sel),       0);
        check("rst_in_ready",  32'(bus.in_ready),  1);
        check("rst_busy",      32'(busy),          0);
        rst_n = 1'b1;
        idle(2);

        // Round-robin, burst 1, back-to-back A0..A8 -> sinks 0..7, 0
        t0 = cyc;
        for (int i = 0; i < 9; i++) send_word(8'hA0 + 8'(i), i % 8);
        check("stream_cycles", 32'(cyc - t0), 9);
        idle(3);
        check("stream_cur_sel", 32'(cur_sel), 1);

        // Burst length 3, 7 words -> 0,0,0,1,1,1,2
        do_reset();
        burst_len = 4'd3;
        idle(2);
        send_word(8'hB0, 0);
        send_word(8'hB1, 0);
        send_word(8'hB2, 0);
        send_word(8'hB3, 1);
        send_word(8'hB4, 1);
        send_word(8'hB5, 1);
        send_word(8'hB6, 2);
        idle(3);
        check("burst_cur_sel", 32'(cur_sel), 2);

        // Backpressure on sink 2 for 4 cycles; other sinks ready
        bus.out_ready = 8'hFB;
        send_word(8'h55, 2);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 'h04);
            check("stall_out_data",  32'(bus.out_data),  'h55);
            check("stall_in_ready",  32'(bus.in_ready),  0);
            check("stall_busy",      32'(busy),          1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 8'hFF;
        idle(3);
        check("bp_cur_sel", 32'(cur_sel), 2);
        check("bp_idle_busy", 32'(busy), 0);

        // Fixed destination 5
        mode    = 1'b1;
        fix_sel = 3'd5;
        idle(2);
        check("fix_cur_sel", 32'(cur_sel), 5);
        send_word(8'hC0, 5);
        send_word(8'hC1, 5);
        send_word(8'hC2, 5);
        idle(3);

        // Mode change while LOADED is held off until an idle EMPTY cycle
        bus.out_ready = 8'hDF;
        send_word(8'h61, 5);
        mode = 1'b0;
        fork
            send_word(8'h62, 5);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 8'hFF;
            end
        join
        check("fix_hold_cur_sel", 32'(cur_sel), 5);
        check("fix_hold_out_valid", 32'(bus.out_valid), 'h20);
        idle(3);
        check("rr_resume_cur_sel", 32'(cur_sel), 2);

        // Asynchronous reset while loaded and stalled
        bus.out_ready = 8'h00;
        send_word(8'h77, 2);
        bus.in_valid = 1'b0;
        #2;
        check("pre_arst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 'h00);
        check("arst_busy",      32'(busy),          0);
        check("arst_cur_sel",   32'(cur_sel),       0);
        check("arst_in_ready",  32'(bus.in_ready),  1);
        check("arst_state",     32'(dbg_state),     32'(ST_EMPTY));
        repeat (2) @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 8'hFF;
        send_word(8'h88, 0);
        idle(3);

        check("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
